// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared constants, state encoding and helpers for the PC sequencer
package pc_seq_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] RESET_VEC_DEF = 32'h0040_0000;
  localparam logic [PC_W-1:0] TRAP_VEC_DEF  = 32'h0040_0004;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Which source the redirect mux picked this cycle; the FSM keys its updates off this.
  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_BOOT = 3'd1,
    SEL_EXC  = 3'd2,
    SEL_ERET = 3'd3,
    SEL_PEND = 3'd4,
    SEL_JMP  = 3'd5,
    SEL_BR   = 3'd6,
    SEL_SEQ  = 3'd7
  } sel_t;

  function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] t);
    return t & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - control/redirect bundle between the pipeline and the PC sequencer
interface pc_seq_if;
  import pc_seq_pkg::*;

  logic [PC_W-1:0] pc;
  logic            stall;
  logic            br_valid;
  logic [PC_W-1:0] br_target;
  logic            jmp_valid;
  logic [PC_W-1:0] jmp_target;
  logic            exc;
  logic            eret;

  logic            pc_ena;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] epc;
  logic            in_trap;
  logic [1:0]      state;
  logic [PC_W-1:0] pc_q;

  modport master (
    output pc, stall, br_valid, br_target, jmp_valid, jmp_target, exc, eret,
    input  pc_ena, pc_next, epc, in_trap, state, pc_q
  );

  modport slave (
    input  pc, stall, br_valid, br_target, jmp_valid, jmp_target, exc, eret,
    output pc_ena, pc_next, epc, in_trap, state, pc_q
  );

endinterface

// File: rtl/pc_redirect_mux.sv
// rtl/pc_redirect_mux.sv - combinational next-PC priority selection and target alignment
module pc_redirect_mux
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [PC_W-1:0] TRAP_VEC  = TRAP_VEC_DEF
) (
  input  logic            rst,
  input  state_t          state,
  input  logic            stall,
  input  logic [PC_W-1:0] pc,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            exc,
  input  logic            eret,
  input  logic            in_trap,
  input  logic [PC_W-1:0] epc,
  input  logic            pend_valid,
  input  logic [PC_W-1:0] pend_target,
  output logic            pc_ena,
  output logic [PC_W-1:0] pc_next,
  output sel_t            sel
);

  logic exc_ok;
  logic eret_ok;

  // A nested exc is dropped, and eret outside the handler counts as absent.
  assign exc_ok  = exc & ~in_trap;
  assign eret_ok = eret & in_trap;

  always_comb begin
    sel = SEL_HOLD;
    if (rst) begin
      sel = SEL_HOLD;
    end else begin
      case (state)
        ST_BOOT: sel = SEL_BOOT;
        ST_RUN, ST_HOLD: begin
          if (exc_ok)                          sel = SEL_EXC;
          else if (stall)                      sel = SEL_HOLD;
          else if (state == ST_HOLD && pend_valid) sel = SEL_PEND;
          else if (eret_ok)                    sel = SEL_ERET;
          else if (jmp_valid)                  sel = SEL_JMP;
          else if (br_valid)                   sel = SEL_BR;
          else                                 sel = SEL_SEQ;
        end
        default: sel = SEL_BOOT;
      endcase
    end
  end

  always_comb begin
    pc_ena  = 1'b1;
    pc_next = pc;
    case (sel)
      SEL_HOLD: begin
        pc_ena  = 1'b0;
        pc_next = rst ? RESET_VEC : pc;
      end
      SEL_BOOT: pc_next = RESET_VEC;
      SEL_EXC:  pc_next = TRAP_VEC;
      SEL_ERET: pc_next = epc + PC_W'(4);
      SEL_PEND: pc_next = align(pend_target);
      SEL_JMP:  pc_next = align(jmp_target);
      SEL_BR:   pc_next = align(br_target);
      SEL_SEQ:  pc_next = pc + PC_W'(4);
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with load enable
module pc_reg
  import pc_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [PC_W-1:0] d,
  output logic [PC_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - PC sequencer: boot/run/hold FSM, trap context, pending redirect and PC register
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [PC_W-1:0] TRAP_VEC  = TRAP_VEC_DEF
) (
  input logic     clk,
  input logic     rst,
  pc_seq_if.slave bus
);

  state_t          state_q;
  logic            in_trap_q;
  logic [PC_W-1:0] epc_q;
  logic            pend_valid_q;
  logic            pend_is_jmp_q;
  logic [PC_W-1:0] pend_target_q;

  sel_t            sel;
  logic            pc_ena;
  logic [PC_W-1:0] pc_next;

  pc_redirect_mux #(
    .RESET_VEC (RESET_VEC),
    .TRAP_VEC  (TRAP_VEC)
  ) u_mux (
    .rst         (rst),
    .state       (state_q),
    .stall       (bus.stall),
    .pc          (bus.pc),
    .br_valid    (bus.br_valid),
    .br_target   (bus.br_target),
    .jmp_valid   (bus.jmp_valid),
    .jmp_target  (bus.jmp_target),
    .exc         (bus.exc),
    .eret        (bus.eret),
    .in_trap     (in_trap_q),
    .epc         (epc_q),
    .pend_valid  (pend_valid_q),
    .pend_target (pend_target_q),
    .pc_ena      (pc_ena),
    .pc_next     (pc_next),
    .sel         (sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      in_trap_q     <= 1'b0;
      epc_q         <= '0;
      pend_valid_q  <= 1'b0;
      pend_is_jmp_q <= 1'b0;
      pend_target_q <= '0;
    end else begin
      case (sel)
        SEL_HOLD: begin
          state_q <= ST_HOLD;
          // A jmp always wins; a br only lands if nothing or another br is pending.
          if (bus.jmp_valid) begin
            pend_valid_q  <= 1'b1;
            pend_is_jmp_q <= 1'b1;
            pend_target_q <= align(bus.jmp_target);
          end else if (bus.br_valid && !(pend_valid_q && pend_is_jmp_q)) begin
            pend_valid_q  <= 1'b1;
            pend_is_jmp_q <= 1'b0;
            pend_target_q <= align(bus.br_target);
          end
        end
        SEL_EXC: begin
          state_q      <= ST_RUN;
          epc_q        <= bus.pc;
          in_trap_q    <= 1'b1;
          pend_valid_q <= 1'b0;
        end
        SEL_ERET: begin
          state_q      <= ST_RUN;
          in_trap_q    <= 1'b0;
          pend_valid_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_RUN;
          pend_valid_q <= 1'b0;
        end
      endcase
    end
  end

  pc_reg u_pc_reg (
    .clk (clk),
    .rst (rst),
    .ena (pc_ena),
    .d   (pc_next),
    .q   (bus.pc_q)
  );

  assign bus.pc_ena  = pc_ena;
  assign bus.pc_next = pc_next;
  assign bus.epc     = epc_q;
  assign bus.in_trap = in_trap_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed bench for pc_seq with the PC register fed back into pc
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        use_force = 1'b0;
  logic [31:0] force_val = '0;
  int          vectors = 0;
  int          miscompares = 0;

  pc_seq_if bus ();

  pc_seq #(
    .RESET_VEC (32'h0040_0000),
    .TRAP_VEC  (32'h0040_0004)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.pc = use_force ? force_val : bus.pc_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 0; bus.br_valid = 0; bus.br_target = '0;
    bus.jmp_valid = 0; bus.jmp_target = '0; bus.exc = 0; bus.eret = 0;
  endtask

  task automatic neg();
    @(negedge clk);
    idle();
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    edge_settle();
    edge_settle();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_in_trap", 32'(bus.in_trap), 32'd0);
    @(negedge clk); #1;
    chk("rst_pc_ena", 32'(bus.pc_ena), 32'd0);
    chk("rst_pc_next", bus.pc_next, 32'h0040_0000);

    // Boot load then sequential run
    neg(); rst = 0; #1;
    chk("boot_ena", 32'(bus.pc_ena), 32'd1);
    chk("boot_next", bus.pc_next, 32'h0040_0000);
    edge_settle();
    chk("boot_pc", bus.pc_q, 32'h0040_0000);
    chk("boot_to_run", 32'(bus.state), 32'd1);
    neg(); edge_settle();
    chk("seq_pc1", bus.pc_q, 32'h0040_0004);
    neg(); edge_settle();
    chk("seq_pc2", bus.pc_q, 32'h0040_0008);
    neg(); edge_settle();
    neg(); edge_settle();
    chk("seq_pc4", bus.pc_q, 32'h0040_0010);

    // Branch target alignment
    neg(); bus.br_valid = 1; bus.br_target = 32'h0040_0103; #1;
    chk("br_next", bus.pc_next, 32'h0040_0100);
    edge_settle();
    chk("br_pc", bus.pc_q, 32'h0040_0100);

    // jmp beats br
    neg(); bus.jmp_valid = 1; bus.jmp_target = 32'h1000_0007;
    bus.br_valid = 1; bus.br_target = 32'h0000_2000; #1;
    chk("jmp_over_br", bus.pc_next, 32'h1000_0004);
    edge_settle();
    chk("jmp_pc", bus.pc_q, 32'h1000_0004);

    // Three stall cycles; jmp pulsed first, lower-priority br must not displace it
    neg(); bus.stall = 1; bus.jmp_valid = 1; bus.jmp_target = 32'h0000_2000; #1;
    chk("stall_ena", 32'(bus.pc_ena), 32'd0);
    edge_settle();
    chk("stall_pc1", bus.pc_q, 32'h1000_0004);
    chk("stall_state", 32'(bus.state), 32'd2);
    neg(); bus.stall = 1; bus.br_valid = 1; bus.br_target = 32'h0000_3000;
    edge_settle();
    chk("stall_pc2", bus.pc_q, 32'h1000_0004);
    neg(); bus.stall = 1;
    edge_settle();
    chk("stall_pc3", bus.pc_q, 32'h1000_0004);
    neg(); bus.br_valid = 1; bus.br_target = 32'h0000_5000; #1;
    chk("unstall_ena", 32'(bus.pc_ena), 32'd1);
    chk("unstall_next", bus.pc_next, 32'h0000_2000);
    edge_settle();
    chk("pend_pc", bus.pc_q, 32'h0000_2000);
    chk("pend_state", 32'(bus.state), 32'd1);

    // Hold with nothing pending resumes sequentially
    neg(); bus.stall = 1;
    edge_settle();
    neg(); edge_settle();
    chk("hold_seq_pc", bus.pc_q, 32'h0000_2004);

    // Exception entry, nested exc ignored, exc+eret in trap -> eret
    neg(); bus.jmp_valid = 1; bus.jmp_target = 32'h0040_0020;
    edge_settle();
    neg(); bus.exc = 1; #1;
    chk("exc_next", bus.pc_next, 32'h0040_0004);
    edge_settle();
    chk("exc_pc", bus.pc_q, 32'h0040_0004);
    chk("exc_epc", bus.epc, 32'h0040_0020);
    chk("exc_in_trap", 32'(bus.in_trap), 32'd1);
    neg(); bus.exc = 1; #1;
    chk("exc2_ignored", bus.pc_next, 32'h0040_0008);
    edge_settle();
    chk("exc2_epc", bus.epc, 32'h0040_0020);
    neg(); bus.exc = 1; bus.eret = 1; #1;
    chk("eret_next", bus.pc_next, 32'h0040_0024);
    edge_settle();
    chk("eret_pc", bus.pc_q, 32'h0040_0024);
    chk("eret_in_trap", 32'(bus.in_trap), 32'd0);
    neg(); bus.eret = 1; #1;
    chk("eret_ignored", bus.pc_next, 32'h0040_0028);
    edge_settle();

    // exc overrides stall and discards the pending jmp
    neg(); bus.stall = 1; bus.jmp_valid = 1; bus.jmp_target = 32'h0000_7000;
    edge_settle();
    neg(); bus.stall = 1; bus.exc = 1; #1;
    chk("exc_stall_ena", 32'(bus.pc_ena), 32'd1);
    chk("exc_stall_next", bus.pc_next, 32'h0040_0004);
    edge_settle();
    chk("exc_stall_epc", bus.epc, 32'h0040_0028);
    chk("exc_stall_state", 32'(bus.state), 32'd1);
    neg(); #1;
    chk("pend_dropped", bus.pc_next, 32'h0040_0008);
    edge_settle();
    neg(); bus.eret = 1; #1;
    chk("eret2_next", bus.pc_next, 32'h0040_002C);
    edge_settle();

    // Sequential wrap at the top of the address space
    neg(); use_force = 1; force_val = 32'hFFFF_FFFC; #1;
    chk("wrap_next", bus.pc_next, 32'h0000_0000);
    edge_settle();
    chk("wrap_pc", bus.pc_q, 32'h0000_0000);
    use_force = 0;

    // Reset mid-hold with a pending br, and mid-trap
    neg(); bus.exc = 1;
    edge_settle();
    neg(); bus.stall = 1; bus.br_valid = 1; bus.br_target = 32'h0000_9000;
    edge_settle();
    chk("pre_rst_state", 32'(bus.state), 32'd2);
    neg(); rst = 1; bus.stall = 1; #1;
    chk("rst_hold_ena", 32'(bus.pc_ena), 32'd0);
    chk("rst_hold_next", bus.pc_next, 32'h0040_0000);
    edge_settle();
    chk("rst_hold_state", 32'(bus.state), 32'd0);
    chk("rst_trap_cleared", 32'(bus.in_trap), 32'd0);
    chk("rst_epc_cleared", bus.epc, 32'h0);
    neg(); rst = 0; #1;
    chk("reboot_next", bus.pc_next, 32'h0040_0000);
    edge_settle();
    chk("reboot_pc", bus.pc_q, 32'h0040_0000);
    neg(); #1;
    chk("reboot_no_pend", bus.pc_next, 32'h0040_0004);
    edge_settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter RESET_VEC, default 32'h0040_0000, boot address loaded into the PC register after reset.
REQ-002 Parameter TRAP_VEC, default 32'h0040_0004, exception handler entry address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  current PC, fed back from the PC register output.
REQ-006 stall  input  1  pipeline stall; the PC must hold.
REQ-007 br_valid / br_target  input  1 / 32  taken-branch redirect request and its target.
REQ-008 jmp_valid / jmp_target  input  1 / 32  jump redirect request and its target.
REQ-009 exc  input  1  exception request.
REQ-010 eret  input  1  return-from-exception request.
REQ-011 pc_ena  output  1  load enable driven to the PC register.
REQ-012 pc_next  output  32  next-PC value driven to the PC register data input.
REQ-013 epc  output  32  saved exception PC.
REQ-014 in_trap  output  1  high while inside the exception handler.
REQ-015 state  output  2  FSM state, for debug: BOOT=0, RUN=1, HOLD=2.

Function
REQ-016 FSM states: BOOT, RUN, HOLD; transitions are registered and pc_next/pc_ena are combinational from state, registers, and inputs.
REQ-017 BOOT: pc_ena=1 and pc_next=RESET_VEC for exactly one cycle, then -> RUN regardless of other inputs.
REQ-018 RUN, stall=0: pc_ena=1; pc_next follows priority exc > eret > jmp > br > sequential (pc+4).
REQ-019 Sequential increment: pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 All redirect targets have bits [1:0] forced to 0 before use.
REQ-021 exc accepted when in_trap=0: epc<=pc, in_trap<=1, pc_next=TRAP_VEC; exc while in_trap=1 is ignored.
REQ-022 eret accepted when in_trap=1: pc_next=epc+4, in_trap<=0; eret while in_trap=0 is ignored and treated as absent.
REQ-023 RUN, stall=1 -> HOLD; pc_ena=0; the highest-priority jmp/br present that cycle is latched into a one-entry pending-redirect register.
REQ-024 HOLD: pc_ena=0 while stall=1; a later jmp/br overwrites pending only if it has equal or higher priority (jmp > br).
REQ-025 HOLD, stall falls: pc_ena=1; pc_next=pending target if valid (and jmp/br inputs that cycle are ignored), else normal RUN selection; pending is cleared; -> RUN.
REQ-026 exc overrides stall in RUN or HOLD: redirects to TRAP_VEC with pc_ena=1, clears pending, -> RUN.
REQ-027 Redirect latency: a redirect accepted in cycle N appears on pc in cycle N+1.
REQ-028 exc and eret in the same cycle: exc wins if in_trap=0, else eret wins.

Reset
REQ-029 rst=1 at a clock edge: state<=BOOT, epc<=0, in_trap<=0, pending cleared; rst overrides all other inputs.
REQ-030 While rst=1: pc_ena=0 and pc_next=RESET_VEC.
REQ-031 rst asserted mid-HOLD or mid-trap discards all saved context; the first post-reset load is RESET_VEC.

Structure
REQ-032 A shared package holds the state encoding, RESET_VEC/TRAP_VEC defaults, and the width constant 32.
REQ-033 Sub-module pc_redirect_mux implements the combinational priority selection and alignment, and is instantiated once; pc_seq instantiates the existing PC register alongside it in the integration top.

Verification
REQ-034 rst 2 cycles then release -> pc=32'h0040_0000 one edge after BOOT; thereafter pc increments by 4 each cycle.
REQ-035 pc=32'h0040_0010, br_valid with br_target=32'h0040_0103 -> next pc=32'h0040_0100.
REQ-036 stall high 3 cycles with jmp_target=32'h0000_2000 pulsed in the first stall cycle -> pc frozen for 3 cycles, then pc=32'h0000_2000.
REQ-037 exc at pc=32'h0040_0020 -> pc=TRAP_VEC, epc=32'h0040_0020, in_trap=1; a second exc is ignored; eret -> pc=32'h0040_0024, in_trap=0.
REQ-038 Force pc=32'hFFFF_FFFC with no redirects -> pc_next=32'h0000_0000.
REQ-039 rst during HOLD with a pending branch -> pending is lost and the first load is 32'h0040_0000.
